// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg: register map, STATUS bit positions and FSM state type for wb_uart |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  localparam int STAT_RX_AVAIL  = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_TX_IDLE   = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_sync_fifo: single-clock FIFO; push into a full FIFO is always dropped   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_full_cnt);
  assign empty     = (r_count == '0);
  // Full is judged on the count at the start of the cycle, so a same-cycle pop cannot make room.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/wb_uart.sv
// +----------------------------------------------------------------------------+
// | wb_uart: pipelined Wishbone 8N1 UART with TX/RX FIFOs and sticky status    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_uart
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4,
  parameter logic [15:0] DIV_RST  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  logic        w_req, w_wr, w_rd, w_stat_wr;
  logic [1:0]  w_sel;
  logic [15:0] w_rdata;
  logic        w_unused;

  logic        r_ack;
  logic [15:0] r_dat_o;
  logic [15:0] r_div;
  logic        r_overrun, r_frame_err;

  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]  w_tx_dout;
  uart_state_t r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd;

  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]  w_rx_dout;
  uart_state_t r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;

  assign w_req     = wb_cyc & wb_stb;
  assign w_wr      = w_req & wb_we;
  assign w_rd      = w_req & ~wb_we;
  assign w_sel     = wb_adr[2:1];
  assign w_stat_wr = w_wr & (w_sel == REG_STAT);
  assign w_unused  = ^{wb_adr[15:3], wb_adr[0]};

  assign w_tx_push = w_wr & (w_sel == REG_DATA);
  assign w_rx_pop  = w_rd & (w_sel == REG_DATA) & ~w_rx_empty;
  assign w_tx_pop  = ~w_tx_empty &
                     ((r_tx_state == IDLE) || ((r_tx_state == STOP) && (r_tx_cnt == '0)));
  assign w_rx_push = (r_rx_state == STOP) && (r_rx_cnt == '0);

  assign wb_ack   = r_ack;
  assign wb_dat_o = r_dat_o;
  assign wb_stall = 1'b0;
  assign txd      = r_txd;
  assign irq      = ~w_rx_empty | r_overrun | r_frame_err;

  wb_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_tx_push), .din(wb_dat_i[7:0]), .pop(w_tx_pop),
    .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
  );

  wb_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_push), .din(r_rx_shift), .pop(w_rx_pop),
    .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
  );

  always_comb begin
    w_rdata = 16'h0000;
    case (w_sel)
      REG_DATA: if (!w_rx_empty) w_rdata = {8'h00, w_rx_dout};
      REG_STAT: begin
        w_rdata[STAT_RX_AVAIL]  = ~w_rx_empty;
        w_rdata[STAT_TX_FULL]   = w_tx_full;
        w_rdata[STAT_TX_IDLE]   = w_tx_empty & (r_tx_state == IDLE);
        w_rdata[STAT_OVERRUN]   = r_overrun;
        w_rdata[STAT_FRAME_ERR] = r_frame_err;
      end
      REG_DIV:  w_rdata = r_div;
      default:  w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_dat_o     <= 16'h0000;
      r_div       <= DIV_RST;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_dat_o <= w_rd ? w_rdata : 16'h0000;
      if (w_wr && (w_sel == REG_DIV)) r_div <= wb_dat_i;
      // A set in the same cycle as a write-1 clear takes priority.
      if (w_rx_push && w_rx_full)
        r_overrun <= 1'b1;
      else if (w_stat_wr && wb_dat_i[STAT_OVERRUN])
        r_overrun <= 1'b0;
      if (w_rx_push && !r_rx_s2)
        r_frame_err <= 1'b1;
      else if (w_stat_wr && wb_dat_i[STAT_FRAME_ERR])
        r_frame_err <= 1'b0;
    end
  end

  // Counters reload from r_div only at a bit boundary, so a DIV write never alters the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (!w_tx_empty) begin
            r_tx_state <= START;
            r_tx_cnt   <= r_div;
            r_tx_shift <= w_tx_dout;
            r_txd      <= 1'b0;
          end
        end
        START: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= DATA;
            r_tx_cnt   <= r_div;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_div;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= STOP;
              r_txd      <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          if (r_tx_cnt == '0) begin
            if (!w_tx_empty) begin
              r_tx_state <= START;
              r_tx_cnt   <= r_div;
              r_tx_shift <= w_tx_dout;
              r_txd      <= 1'b0;
            end else begin
              r_tx_state <= IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= START;
            r_rx_cnt   <= r_div >> 1;
          end
        end
        START: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) begin
              r_rx_state <= IDLE;
            end else begin
              r_rx_state <= DATA;
              r_rx_cnt   <= r_div;
              r_rx_bit   <= '0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_div;
            if (r_rx_bit == 3'd7) r_rx_state <= STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == '0) r_rx_state <= IDLE;
          else                r_rx_cnt   <= r_rx_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_uart.sv
// +----------------------------------------------------------------------------+
// | tb_wb_uart: directed + random bench for wb_uart with a frame-level model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_uart;

  localparam int          TX_DEPTH = 4;
  localparam int          RX_DEPTH = 4;
  localparam logic [15:0] DIV_RST  = 16'd433;
  localparam logic [15:0] A_DATA = 16'h5000, A_STAT = 16'h5002, A_DIV = 16'h5004, A_RSV = 16'h5006;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] wb_adr = '0, wb_dat_i = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [15:0] wb_dat_o;
  logic        wb_ack, wb_stall, txd, irq;
  logic        rxd = 1'b1;

  int checks = 0, failures = 0;
  logic [7:0] exp_bytes[$];
  logic       txd_log[$];
  bit         rec_en = 1'b0;
  logic [7:0] rx_q[$];
  bit         m_ovr = 1'b0, m_ferr = 1'b0;

  wb_uart #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_stall(wb_stall),
    .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) txd_log.push_back(txd);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat(input bit rx_av, input bit tx_full, input bit tx_idle,
                                       input bit ovr, input bit ferr);
    return {11'd0, ferr, ovr, tx_idle, tx_full, rx_av};
  endfunction

  task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                         output logic [15:0] rdat);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("ack", {15'd0, wb_ack}, 16'd1);
    rdat = wb_dat_o;
    @(negedge clk);
    check("ack_single", {15'd0, wb_ack}, 16'd0);
    check("dat_o_idle", wb_dat_o, 16'h0000);
  endtask

  task automatic wb_wr(input logic [15:0] adr, input logic [15:0] wdat);
    logic [15:0] d;
    wb_xfer(1'b1, adr, wdat, d);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [15:0] adr, input logic [15:0] exp);
    logic [15:0] d;
    wb_xfer(1'b0, adr, 16'h0000, d);
    check(tag, d, exp);
  endtask

  // Expected line: each queued byte as start(0), 8 data bits LSB first, stop(1), each DIV+1 cycles.
  task automatic check_tx(input string tag, input int div);
    int start = -1, errs = 0, idx = 0, len;
    logic bv;
    len = exp_bytes.size() * 10 * (div + 1);
    for (int i = 0; i < txd_log.size(); i++)
      if (start < 0 && txd_log[i] === 1'b0) start = i;
    if (exp_bytes.size() == 0) begin
      for (int i = 0; i < txd_log.size(); i++) if (txd_log[i] !== 1'b1) errs++;
    end else if (start < 0) begin
      errs = 1;
    end else begin
      for (int f = 0; f < exp_bytes.size(); f++)
        for (int b = 0; b < 10; b++)
          for (int c = 0; c <= div; c++) begin
            idx = start + (f * 10 + b) * (div + 1) + c;
            bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_bytes[f][b-1];
            if (idx >= txd_log.size() || txd_log[idx] !== bv) errs++;
          end
      for (int i = start + len; i < txd_log.size(); i++) if (txd_log[i] !== 1'b1) errs++;
    end
    check(tag, 16'(errs), 16'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (div + 1) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (div + 1) @(negedge clk);
    if (!stop) m_ferr = 1'b1;
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] burst[6];
    int waited;

    // Reset state
    #12;
    check("rst_txd", {15'd0, txd}, 16'd1);
    check("rst_ack", {15'd0, wb_ack}, 16'd0);
    check("rst_dat_o", wb_dat_o, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("stall", {15'd0, wb_stall}, 16'd0);
    @(negedge clk); rst = 1'b0;
    wb_rd_chk("rst_status", A_STAT, stat(0, 0, 1, 0, 0));
    wb_rd_chk("rst_div", A_DIV, DIV_RST);
    wb_rd_chk("rsv_read", A_RSV, 16'h0000);
    wb_wr(A_RSV, 16'hFFFF);
    wb_rd_chk("rsv_after_wr", A_RSV, 16'h0000);

    // Single TX frames at DIV=3: 8'hA5 then two random bytes
    wb_wr(A_DIV, 16'd3);
    wb_rd_chk("div_rb", A_DIV, 16'd3);
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      exp_bytes.delete(); exp_bytes.push_back(b);
      txd_log.delete(); rec_en = 1'b1;
      wb_wr(A_DATA, {8'h00, b});
      repeat (50) @(negedge clk);
      rec_en = 1'b0;
      check_tx("tx_single", 3);
      wb_rd_chk("tx_idle_after", A_STAT, stat(0, 0, 1, 0, 0));
    end

    // Burst of TX_DEPTH+2 writes: the first byte leaves the FIFO when the FSM starts, so
    // TX_DEPTH+1 bytes are kept and the last write is dropped.
    for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
    exp_bytes.delete();
    for (int i = 0; i < TX_DEPTH + 1; i++) exp_bytes.push_back(burst[i]);
    txd_log.delete(); rec_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) check("burst_ack", {15'd0, wb_ack}, 16'd1);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = A_DATA; wb_dat_i = {8'h00, burst[i]};
    end
    @(negedge clk);
    check("burst_ack_last", {15'd0, wb_ack}, 16'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("burst_ack_drop", {15'd0, wb_ack}, 16'd0);
    wb_rd_chk("burst_full", A_STAT, stat(0, 1, 0, 0, 0));
    repeat (5 * 40 + 20) @(negedge clk);
    rec_en = 1'b0;
    check_tx("tx_burst", 3);
    wb_rd_chk("burst_idle", A_STAT, stat(0, 0, 1, 0, 0));

    // RX at DIV=7: 8'h3C then read-out and empty read
    wb_wr(A_DIV, 16'd7);
    send_rx(8'h3C, 1'b1, 7);
    repeat (4) @(negedge clk);
    wb_rd_chk("rx_avail", A_STAT, stat(rx_q.size() != 0, 0, 1, m_ovr, m_ferr));
    check("rx_irq", {15'd0, irq}, {15'd0, (rx_q.size() != 0) | m_ovr | m_ferr});
    wb_rd_chk("rx_data", A_DATA, {8'h00, rx_q.pop_front()});
    wb_rd_chk("rx_empty_read", A_DATA, 16'h0000);
    wb_rd_chk("rx_empty_stat", A_STAT, stat(0, 0, 1, 0, 0));
    check("rx_irq_clear", {15'd0, irq}, 16'd0);

    // RX_DEPTH+1 random frames without reading -> overrun
    for (int i = 0; i < RX_DEPTH + 1; i++) send_rx(8'($urandom), 1'b1, 7);
    repeat (4) @(negedge clk);
    wb_rd_chk("ovr_stat", A_STAT, stat(1, 0, 1, m_ovr, m_ferr));
    check("ovr_irq", {15'd0, irq}, 16'd1);
    wb_wr(A_STAT, 16'h0008);
    m_ovr = 1'b0;
    wb_rd_chk("ovr_cleared", A_STAT, stat(1, 0, 1, m_ovr, m_ferr));
    while (rx_q.size() != 0) wb_rd_chk("rx_fifo_data", A_DATA, {8'h00, rx_q.pop_front()});
    wb_rd_chk("rx_drained", A_STAT, stat(0, 0, 1, 0, 0));

    // Frame with stop bit 0: frame_err set, byte still delivered
    b = 8'($urandom);
    send_rx(b, 1'b0, 7);
    repeat (4) @(negedge clk);
    wb_rd_chk("ferr_stat", A_STAT, stat(1, 0, 1, m_ovr, m_ferr));
    wb_rd_chk("ferr_data", A_DATA, {8'h00, rx_q.pop_front()});
    check("ferr_irq", {15'd0, irq}, 16'd1);
    wb_wr(A_STAT, 16'h0010);
    m_ferr = 1'b0;
    wb_rd_chk("ferr_cleared", A_STAT, stat(0, 0, 1, 0, 0));

    // Reset mid TX frame with bytes pending in both FIFOs
    wb_wr(A_DIV, 16'd3);
    send_rx(8'($urandom), 1'b1, 3);
    wb_wr(A_DATA, 16'h0055);
    wb_wr(A_DATA, 16'h00AA);
    waited = 0;
    while (txd !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("tx_started", {15'd0, txd}, 16'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_txd", {15'd0, txd}, 16'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_bytes.delete();
    txd_log.delete(); rec_en = 1'b1;
    repeat (60) @(negedge clk);
    rec_en = 1'b0;
    check_tx("tx_after_rst", 3);
    wb_rd_chk("stat_after_rst", A_STAT, stat(0, 0, 1, 0, 0));
    wb_rd_chk("rx_after_rst", A_DATA, 16'h0000);
    wb_rd_chk("div_after_rst", A_DIV, DIV_RST);
    check("irq_after_rst", {15'd0, irq}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
